// File: rtl/serial_word_shifter_pkg.sv
// Shared types and constants for serial_word_shifter and its holding buffer.
package serial_word_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  function automatic int cnt_width(input int width);
    return $clog2(width + 32'sd1);
  endfunction

endpackage

// File: rtl/swsh_hold_buf.sv
// One-word holding buffer with its full flag and the registered in_ready.
module swsh_hold_buf
  import serial_word_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             consume,
  input  logic             bypass,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             in_ready
);

  logic             full_r;
  logic             in_ready_r;
  logic [WIDTH-1:0] data_r;
  logic             write_s;
  logic             full_next_s;

  // Next occupancy: a word taken straight into the shift register bypasses the buffer.
  always_comb begin
    write_s = in_valid & in_ready_r & ~bypass;
    if (consume) begin
      full_next_s = 1'b0;
    end else if (write_s) begin
      full_next_s = 1'b1;
    end else begin
      full_next_s = full_r;
    end
  end

  // Buffer storage and ready flag; in_ready reflects the occupancy after this edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      full_r     <= 1'b0;
      in_ready_r <= 1'b0;
      data_r     <= '0;
    end else begin
      full_r     <= full_next_s;
      in_ready_r <= ~full_next_s;
      if (write_s) begin
        data_r <= in_data;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign full     = full_r;
  assign data     = data_r;
  assign in_ready = in_ready_r;

endmodule

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial front end: MSB-first words on dataout with a one-word holding buffer.
// Optional trailing even-parity bit when SERIAL_WORD_SHIFTER_PARITY_EN is defined.
module serial_word_shifter
  import serial_word_shifter_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             dataout,
  output logic             bit_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 32'sd1);

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             dataout_r;
  logic             bit_valid_r;
  logic             word_start_r;
  logic             busy_r;

  logic             hold_full_s;
  logic [WIDTH-1:0] hold_data_s;
  logic             in_ready_s;
  logic             xfer_s;
  logic             next_word_s;
  logic             pop_s;
  logic             load_direct_s;
  logic             load_s;
  logic [WIDTH-1:0] load_word_s;

`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
  logic             parity_r;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  swsh_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold_buf (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .consume  (pop_s),
    .bypass   (load_direct_s),
    .full     (hold_full_s),
    .data     (hold_data_s),
    .in_ready (in_ready_s)
  );

  // Decide whether the shift register takes a new word at this edge, and from where.
  always_comb begin
    xfer_s      = in_valid & in_ready_s;
    next_word_s = 1'b0;
    case (state_r)
      IDLE:    next_word_s = 1'b1;
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
      SHIFT:   next_word_s = 1'b0;
      PAR:     next_word_s = 1'b1;
`else
      SHIFT:   next_word_s = (cnt_r == LAST_CNT);
`endif
      default: next_word_s = 1'b1;
    endcase
    pop_s         = next_word_s & hold_full_s;
    load_direct_s = next_word_s & ~hold_full_s & xfer_s;
    load_s        = pop_s | load_direct_s;
    if (pop_s) begin
      load_word_s = hold_data_s;
    end else begin
      load_word_s = in_data;
    end
  end

  // FSM, shift register and bit counter; the MSB of a new word goes straight to dataout_r.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= IDLE;
      shreg_r      <= '0;
      cnt_r        <= '0;
      dataout_r    <= IDLE_BIT;
      bit_valid_r  <= 1'b0;
      word_start_r <= 1'b0;
      busy_r       <= 1'b0;
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
      parity_r     <= 1'b0;
`endif
    end else if (load_s) begin
      state_r      <= SHIFT;
      shreg_r      <= {load_word_s[WIDTH-2:0], 1'b0};
      cnt_r        <= '0;
      dataout_r    <= load_word_s[WIDTH-1];
      bit_valid_r  <= 1'b1;
      word_start_r <= 1'b1;
      busy_r       <= 1'b1;
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
      parity_r     <= even_parity(load_word_s);
`endif
    end else begin
      case (state_r)
        SHIFT: begin
          if (cnt_r != LAST_CNT) begin
            shreg_r      <= {shreg_r[WIDTH-2:0], 1'b0};
            cnt_r        <= cnt_r + CW'(1'b1);
            dataout_r    <= shreg_r[WIDTH-1];
            bit_valid_r  <= 1'b1;
            word_start_r <= 1'b0;
            busy_r       <= 1'b1;
          end else begin
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
            state_r      <= PAR;
            dataout_r    <= parity_r;
            bit_valid_r  <= 1'b1;
            word_start_r <= 1'b0;
            busy_r       <= 1'b1;
`else
            state_r      <= IDLE;
            dataout_r    <= IDLE_BIT;
            bit_valid_r  <= 1'b0;
            word_start_r <= 1'b0;
            busy_r       <= 1'b0;
`endif
          end
        end
        default: begin
          state_r      <= IDLE;
          dataout_r    <= IDLE_BIT;
          bit_valid_r  <= 1'b0;
          word_start_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_s;
  assign dataout    = dataout_r;
  assign bit_valid  = bit_valid_r;
  assign word_start = word_start_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_serial_word_shifter.sv
// Scoreboard bench for serial_word_shifter (WIDTH=8 and WIDTH=2 instances).
module tb_serial_word_shifter;

  localparam logic TB_IDLE = 1'b0;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, dataout, bit_valid, word_start, busy;

  logic       w2_in_valid = 1'b0;
  logic [1:0] w2_in_data = 2'b00;
  logic       w2_in_ready, w2_dataout, w2_bit_valid, w2_word_start, w2_busy;

  int checks = 0;
  int failures = 0;

  // Each entry is {word_start, dataout} expected for one valid serial bit.
  logic [1:0] sb[$];
  logic [1:0] sb2[$];

  serial_word_shifter #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dataout(dataout), .bit_valid(bit_valid),
    .word_start(word_start), .busy(busy)
  );

  serial_word_shifter #(.WIDTH(2)) dut_w2 (
    .clock(clock), .reset(reset), .in_valid(w2_in_valid), .in_data(w2_in_data),
    .in_ready(w2_in_ready), .dataout(w2_dataout), .bit_valid(w2_bit_valid),
    .word_start(w2_word_start), .busy(w2_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word8(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) sb.push_back({(i == 7), w[i]});
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
    sb.push_back({1'b0, ^w});
`endif
  endtask

  // Stream words with in_valid held high; checks every cycle against the scoreboard.
  task automatic run_stream(input logic [7:0] words[$], input string name, output bit saw_not_ready);
    int idx = 0;
    int cycles = 0;
    int accepted = 0;
    int started = 0;
    bit exp_busy;
    logic [1:0] e;
    saw_not_ready = 1'b0;
    while ((idx < words.size() || sb.size() != 0) && cycles < 300) begin
      @(negedge clock);
      cycles++;
      checks++;
      exp_busy = (sb.size() != 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e[1]) started++;
        if (bit_valid !== 1'b1 || dataout !== e[0] || word_start !== e[1]) begin
          failures++;
          $display("FAIL %s_bit: got valid=%b data=%b start=%b, want valid=1 data=%b start=%b",
                   name, bit_valid, dataout, word_start, e[0], e[1]);
        end
      end else if (bit_valid !== 1'b0 || dataout !== TB_IDLE || word_start !== 1'b0) begin
        failures++;
        $display("FAIL %s_idle: got valid=%b data=%b start=%b, want 0 %b 0",
                 name, bit_valid, dataout, word_start, TB_IDLE);
      end
      checks++;
      if (busy !== exp_busy || in_ready !== (accepted == started)) begin
        failures++;
        $display("FAIL %s_flags: got busy=%b in_ready=%b, want busy=%b in_ready=%b",
                 name, busy, in_ready, exp_busy, (accepted == started));
      end
      if (in_ready === 1'b0) saw_not_ready = 1'b1;
      if (idx < words.size()) begin
        in_valid = 1'b1;
        in_data  = words[idx];
        if (in_ready === 1'b1) begin
          push_word8(words[idx]);
          idx++;
          accepted++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (cycles >= 300) begin
      failures++;
      $display("FAIL %s_timeout: got %0d cycles, want < 300", name, cycles);
    end
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bit_valid !== 1'b0 || dataout !== TB_IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_after: got valid=%b data=%b busy=%b, want 0 %b 0",
               name, bit_valid, dataout, busy, TB_IDLE);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (dataout !== TB_IDLE || bit_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || word_start !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: got data=%b valid=%b busy=%b ready=%b start=%b, want %b 0 0 0 0",
                 dataout, bit_valid, busy, in_ready, word_start, TB_IDLE);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || bit_valid !== 1'b0 || busy !== 1'b0 || dataout !== TB_IDLE) begin
      failures++;
      $display("FAIL reset_release: got ready=%b valid=%b busy=%b data=%b, want 1 0 0 %b",
               in_ready, bit_valid, busy, dataout, TB_IDLE);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] wq[$];
    bit nr;
    wq.push_back(8'hE8);
    run_stream(wq, "single", nr);
  endtask

  task automatic test_back_to_back();
    logic [7:0] wq[$];
    bit nr;
    wq.push_back(8'hFF);
    wq.push_back(8'h1D);
    wq.push_back(8'hA5);
    run_stream(wq, "b2b", nr);
    checks++;
    if (nr !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_low: got in_ready never low, want low while buffer held");
    end
  endtask

  task automatic test_parity();
    logic [7:0] wq[$];
    bit nr;
    wq.push_back(8'h07);
    wq.push_back(8'h03);
    run_stream(wq, "parity", nr);
  endtask

  task automatic test_reset_mid_word();
    logic [2:0] seen;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready: got %b, want 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = 8'hF0;
    @(negedge clock);
    seen[2] = dataout;
    in_data = 8'h3C;
    @(negedge clock);
    seen[1] = dataout;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_held: got ready=%b busy=%b, want 0 1", in_ready, busy);
    end
    @(negedge clock);
    seen[0] = dataout;
    checks++;
    if (seen !== 3'b111) begin
      failures++;
      $display("FAIL midrst_bits: got %b, want 111", seen);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (dataout !== TB_IDLE || bit_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_cleared: got data=%b valid=%b busy=%b ready=%b, want %b 0 0 0",
               dataout, bit_valid, busy, in_ready, TB_IDLE);
    end
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      checks++;
      if (bit_valid !== 1'b0 || dataout !== TB_IDLE) begin
        failures++;
        $display("FAIL midrst_discard: cycle %0d got valid=%b data=%b, want 0 %b",
                 i, bit_valid, dataout, TB_IDLE);
      end
    end
  endtask

  task automatic test_width2();
    logic [1:0] words[2];
    logic [1:0] e;
    int idx = 0;
    int cycles = 0;
    words[0] = 2'b10;
    words[1] = 2'b01;
    while ((idx < 2 || sb2.size() != 0) && cycles < 100) begin
      @(negedge clock);
      cycles++;
      checks++;
      if (sb2.size() != 0) begin
        e = sb2.pop_front();
        if (w2_bit_valid !== 1'b1 || w2_dataout !== e[0] || w2_word_start !== e[1]) begin
          failures++;
          $display("FAIL w2_bit: got valid=%b data=%b start=%b, want valid=1 data=%b start=%b",
                   w2_bit_valid, w2_dataout, w2_word_start, e[0], e[1]);
        end
      end else if (w2_bit_valid !== 1'b0 || w2_dataout !== TB_IDLE) begin
        failures++;
        $display("FAIL w2_idle: got valid=%b data=%b, want 0 %b", w2_bit_valid, w2_dataout, TB_IDLE);
      end
      if (idx < 2) begin
        w2_in_valid = 1'b1;
        w2_in_data  = words[idx];
        if (w2_in_ready === 1'b1) begin
          sb2.push_back({1'b1, words[idx][1]});
          sb2.push_back({1'b0, words[idx][0]});
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
          sb2.push_back({1'b0, ^words[idx]});
`endif
          idx++;
        end
      end else begin
        w2_in_valid = 1'b0;
      end
    end
    w2_in_valid = 1'b0;
    checks++;
    if (cycles >= 100) begin
      failures++;
      $display("FAIL w2_timeout: got %0d cycles, want < 100", cycles);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
`ifdef SERIAL_WORD_SHIFTER_PARITY_EN
    test_parity();
`endif
    test_reset_mid_word();
    test_width2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
